// File: rtl/writeback_pkg.sv
// Shared definitions for the MEM/WB writeback stage: wbSel codes, load funct3
// codes, FSM state encoding and the pending-load record held across a cache miss.
package writeback_pkg;

    localparam int unsigned RD_W = 5;

    // Writeback source select; code 3 is reserved and behaves as WB_ALU.
    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    // Load size/sign encodings from the RV32I funct3 field.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        RUN       = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_e;

    // Fields of a load parked while the data cache has not yet answered.
    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic            reg_write_n;
        logic [2:0]      funct3;
        logic [1:0]      off;
    } pend_load_t;

endpackage

// File: rtl/load_extender.sv
// Combinational load extender: picks the byte/halfword addressed by off out of
// an aligned cache word and sign- or zero-extends it according to funct3.
// Ports: word (aligned cache word), funct3 (load type), off (address[1:0]),
//        result_c (extended XLEN result).
module load_extender
    import writeback_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    output logic [XLEN-1:0] result_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword select ignores off[0], so misaligned halfwords read the enclosing half.
    always_comb begin
        byte_sel = word[{off, 3'b000} +: 8];
        half_sel = off[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        result_c = word;
        unique case (funct3)
            F3_LB:   result_c = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  result_c = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   result_c = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  result_c = {{(XLEN-16){1'b0}}, half_sel};
            default: result_c = word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback stage. Selects ALU result, extended
// load data or PC+4 and drives the register bank; stalls upstream while a load
// waits on the data cache. Also counts retired instructions and stall cycles.
// Ports:
//   clock, reset (async, active-low)
//   in_valid/in_ready          : upstream handshake, in_ready=0 stalls EX/MEM
//   in_rd, in_regWrite, in_wbSel, in_funct3, in_aluResult, in_pcPlus4 : EX/MEM slot
//   cache_rdata, cache_ready   : data cache response
//   rd, regWrite, writeData    : register bank write port (regWrite active-low)
//   retired, stallCycles       : performance counters
module writeback_stage
    import writeback_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rd,
    input  logic             in_regWrite,
    input  logic [1:0]       in_wbSel,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_aluResult,
    input  logic [XLEN-1:0]  in_pcPlus4,
    input  logic [XLEN-1:0]  cache_rdata,
    input  logic             cache_ready,
    output logic [4:0]       rd,
    output logic             regWrite,
    output logic [XLEN-1:0]  writeData,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] stallCycles
);

    wb_state_e        state_q, state_d;
    pend_load_t       pend_q, pend_d;
    logic [RD_W-1:0]  rd_q, rd_d;
    logic             we_n_q, we_n_d;
    logic [XLEN-1:0]  wd_q, wd_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic [2:0]       ext_f3;
    logic [1:0]       ext_off;
    logic [XLEN-1:0]  ext_c;

    logic             wr_en;
    logic [RD_W-1:0]  wr_rd;
    logic             wr_we_n;
    logic [XLEN-1:0]  wr_data;

    // A parked load extends with its latched fields; otherwise use the live slot.
    always_comb begin
        ext_f3  = (state_q == WAIT_LOAD) ? pend_q.funct3 : in_funct3;
        ext_off = (state_q == WAIT_LOAD) ? pend_q.off    : in_aluResult[1:0];
    end

    load_extender #(
        .XLEN (XLEN)
    ) u_load_extender (
        .word     (cache_rdata),
        .funct3   (ext_f3),
        .off      (ext_off),
        .result_c (ext_c)
    );

    // State register and output/counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            pend_q    <= '0;
            rd_q      <= '0;
            we_n_q    <= 1'b1;
            wd_q      <= '0;
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            rd_q      <= rd_d;
            we_n_q    <= we_n_d;
            wd_q      <= wd_d;
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    // Next-state, writeback selection and counter updates.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        rd_d      = rd_q;
        wd_d      = wd_q;
        we_n_d    = 1'b1;
        retired_d = retired_q;
        stall_d   = stall_q;
        wr_en     = 1'b0;
        wr_rd     = rd_q;
        wr_we_n   = 1'b1;
        wr_data   = wd_q;

        unique case (state_q)
            RUN: begin
                if (in_valid) begin
                    if (in_wbSel == WB_LOAD) begin
                        if (cache_ready) begin
                            wr_en   = 1'b1;
                            wr_rd   = in_rd;
                            wr_we_n = in_regWrite;
                            wr_data = ext_c;
                        end else begin
                            pend_d.rd          = in_rd;
                            pend_d.reg_write_n = in_regWrite;
                            pend_d.funct3      = in_funct3;
                            pend_d.off         = in_aluResult[1:0];
                            state_d            = WAIT_LOAD;
                        end
                    end else begin
                        wr_en   = 1'b1;
                        wr_rd   = in_rd;
                        wr_we_n = in_regWrite;
                        wr_data = (in_wbSel == WB_PC4) ? in_pcPlus4 : in_aluResult;
                    end
                end
            end
            WAIT_LOAD: begin
                stall_d = stall_q + CNT_W'(1);
                if (cache_ready) begin
                    wr_en   = 1'b1;
                    wr_rd   = pend_q.rd;
                    wr_we_n = pend_q.reg_write_n;
                    wr_data = ext_c;
                    state_d = RUN;
                end
            end
        endcase

        // x0 is never written; a suppressed write does not retire.
        if (wr_en) begin
            rd_d   = wr_rd;
            wd_d   = wr_data;
            we_n_d = wr_we_n | (wr_rd == '0);
        end
        if (!we_n_d) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    assign in_ready    = (state_q == RUN);
    assign rd          = rd_q;
    assign regWrite    = we_n_q;
    assign writeData   = wd_q;
    assign retired     = retired_q;
    assign stallCycles = stall_q;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_regWrite;
    logic [1:0]  in_wbSel;
    logic [2:0]  in_funct3;
    logic [31:0] in_aluResult;
    logic [31:0] in_pcPlus4;
    logic [31:0] cache_rdata;
    logic        cache_ready;
    logic [4:0]  rd;
    logic        regWrite;
    logic [31:0] writeData;
    logic [31:0] retired;
    logic [31:0] stallCycles;

    int checks = 0;
    int errors = 0;

    writeback_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd        (in_rd),
        .in_regWrite  (in_regWrite),
        .in_wbSel     (in_wbSel),
        .in_funct3    (in_funct3),
        .in_aluResult (in_aluResult),
        .in_pcPlus4   (in_pcPlus4),
        .cache_rdata  (cache_rdata),
        .cache_ready  (cache_ready),
        .rd           (rd),
        .regWrite     (regWrite),
        .writeData    (writeData),
        .retired      (retired),
        .stallCycles  (stallCycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: "is a load outstanding", the parked load, and last outputs.
    bit          m_pend;
    logic [4:0]  p_rd;
    logic        p_we_n;
    logic [2:0]  p_f3;
    logic [1:0]  p_off;
    logic [4:0]  m_rd;
    logic        m_we_n;
    logic [31:0] m_wd;
    logic [31:0] m_ret;
    logic [31:0] m_stall;

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic        we_n;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] rdata;
        logic        cr;
        logic [4:0]  e_rd;
        logic        e_we_n;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? 32'(b - 256) : 32'(b);
            3'b100:  return 32'(b);
            3'b001:  return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            3'b101:  return 32'(h);
            default: return w;
        endcase
    endfunction

    task automatic m_reset();
        m_pend = 0; m_rd = 0; m_we_n = 1; m_wd = 0; m_ret = 0; m_stall = 0;
    endtask

    task automatic m_write(input logic [4:0] r, input logic w, input logic [31:0] d);
        m_rd = r;
        m_wd = d;
        m_we_n = (r == 0) ? 1'b1 : w;
        if (!m_we_n) m_ret = m_ret + 1;
    endtask

    // One clock edge of the reference, from the inputs present at that edge.
    task automatic m_step();
        if (!m_pend) begin
            m_we_n = 1;
            if (in_valid) begin
                if (in_wbSel == 2'd1) begin
                    if (cache_ready) m_write(in_rd, in_regWrite, m_ext(cache_rdata, in_funct3, in_aluResult[1:0]));
                    else begin
                        m_pend = 1; p_rd = in_rd; p_we_n = in_regWrite;
                        p_f3 = in_funct3; p_off = in_aluResult[1:0];
                    end
                end else begin
                    m_write(in_rd, in_regWrite, (in_wbSel == 2'd2) ? in_pcPlus4 : in_aluResult);
                end
            end
        end else begin
            m_stall = m_stall + 1;
            m_we_n = 1;
            if (cache_ready) begin
                m_write(p_rd, p_we_n, m_ext(cache_rdata, p_f3, p_off));
                m_pend = 0;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] r, input logic w, input logic [1:0] s,
                         input logic [2:0] f, input logic [31:0] a, input logic [31:0] p,
                         input logic [31:0] d, input logic c);
        in_valid = v; in_rd = r; in_regWrite = w; in_wbSel = s; in_funct3 = f;
        in_aluResult = a; in_pcPlus4 = p; cache_rdata = d; cache_ready = c;
    endtask

    task automatic tick();
        chk("in_ready", 32'(in_ready), 32'(!m_pend));
        @(posedge clock);
        m_step();
        #1;
        chk("rd", 32'(rd), 32'(m_rd));
        chk("regWrite", 32'(regWrite), 32'(m_we_n));
        chk("writeData", writeData, m_wd);
        chk("retired", retired, m_ret);
        chk("stallCycles", stallCycles, m_stall);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        m_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd5,  1'b0, 2'd0, 3'b000, 32'h0000_002A, 32'h0, 32'h0,         1'b0, 5'd5,  1'b0, 32'h0000_002A};
        vecs[1]  = '{1'b1, 5'd6,  1'b0, 2'd1, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1'b1, 5'd6,  1'b0, 32'hFFFF_FF80};
        vecs[2]  = '{1'b1, 5'd7,  1'b0, 2'd1, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1'b1, 5'd7,  1'b0, 32'h0000_0080};
        vecs[3]  = '{1'b1, 5'd8,  1'b0, 2'd1, 3'b001, 32'h0000_0102, 32'h0, 32'h80FF_1234, 1'b1, 5'd8,  1'b0, 32'hFFFF_80FF};
        vecs[4]  = '{1'b1, 5'd9,  1'b0, 2'd1, 3'b101, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1'b1, 5'd9,  1'b0, 32'h0000_80FF};
        vecs[5]  = '{1'b1, 5'd11, 1'b0, 2'd1, 3'b001, 32'h0000_0100, 32'h0, 32'h80FF_1234, 1'b1, 5'd11, 1'b0, 32'h0000_1234};
        vecs[6]  = '{1'b1, 5'd12, 1'b0, 2'd1, 3'b010, 32'h0000_0101, 32'h0, 32'h80FF_1234, 1'b1, 5'd12, 1'b0, 32'h80FF_1234};
        vecs[7]  = '{1'b1, 5'd13, 1'b0, 2'd1, 3'b011, 32'h0000_0102, 32'h0, 32'h80FF_1234, 1'b1, 5'd13, 1'b0, 32'h80FF_1234};
        vecs[8]  = '{1'b1, 5'd1,  1'b0, 2'd2, 3'b000, 32'h0000_0999, 32'h0000_0048, 32'h0, 1'b0, 5'd1,  1'b0, 32'h0000_0048};
        vecs[9]  = '{1'b1, 5'd2,  1'b1, 2'd0, 3'b010, 32'h0000_0055, 32'h0, 32'h0,         1'b0, 5'd2,  1'b1, 32'h0000_0055};
        vecs[10] = '{1'b1, 5'd0,  1'b0, 2'd0, 3'b000, 32'h0000_0007, 32'h0, 32'h0,         1'b0, 5'd0,  1'b1, 32'h0000_0007};
        vecs[11] = '{1'b1, 5'd4,  1'b0, 2'd3, 3'b000, 32'h0000_0ABC, 32'h0000_0111, 32'h0, 1'b0, 5'd4,  1'b0, 32'h0000_0ABC};
        vecs[12] = '{1'b1, 5'd14, 1'b0, 2'd1, 3'b000, 32'h0000_0201, 32'h0, 32'h0000_7F00, 1'b1, 5'd14, 1'b0, 32'h0000_007F};
        vecs[13] = '{1'b0, 5'd20, 1'b0, 2'd1, 3'b000, 32'h0000_0000, 32'h0, 32'hFFFF_FFFF, 1'b1, 5'd14, 1'b1, 32'h0000_007F};

        // Reset values.
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        m_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_regWrite", 32'(regWrite), 32'd1);
        chk("rst_writeData", writeData, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_stall", stallCycles, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;

        // Single-cycle vectors from RUN.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].valid, vecs[i].rd, vecs[i].we_n, vecs[i].sel, vecs[i].f3,
                  vecs[i].alu, vecs[i].pc4, vecs[i].rdata, vecs[i].cr);
            tick();
            chk($sformatf("vec%0d_rd", i), 32'(rd), 32'(vecs[i].e_rd));
            chk($sformatf("vec%0d_regWrite", i), 32'(regWrite), 32'(vecs[i].e_we_n));
            chk($sformatf("vec%0d_writeData", i), writeData, vecs[i].e_wd);
            if (i == 0) chk("addi_retired", retired, 32'd1);
        end
        chk("table_retired", retired, 32'd11);

        // Load miss: 4 cycles in WAIT_LOAD, held instruction accepted afterwards.
        do_reset();
        drive(1, 5'd10, 0, 2'd1, 3'b010, 32'h0000_1000, 0, 32'h0, 0);
        tick();
        chk("miss_regWrite_bubble", 32'(regWrite), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'd3, 0, 2'd0, 3'b000, 32'h0000_0033, 0, 32'h1111_1111, 0);
            chk("miss_in_ready_wait", 32'(in_ready), 32'd0);
            tick();
            chk("miss_regWrite_wait", 32'(regWrite), 32'd1);
        end
        drive(1, 5'd3, 0, 2'd0, 3'b000, 32'h0000_0033, 0, 32'hDEAD_BEEF, 1);
        chk("miss_in_ready_on_ready", 32'(in_ready), 32'd0);
        tick();
        chk("miss_regWrite", 32'(regWrite), 32'd0);
        chk("miss_writeData", writeData, 32'hDEAD_BEEF);
        chk("miss_rd", 32'(rd), 32'd10);
        chk("miss_stall", stallCycles, 32'd4);
        chk("miss_in_ready_after", 32'(in_ready), 32'd1);
        tick();
        chk("held_rd", 32'(rd), 32'd3);
        chk("held_writeData", writeData, 32'h0000_0033);
        chk("held_retired", retired, 32'd2);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        chk("one_cycle_regWrite", 32'(regWrite), 32'd1);

        // Asynchronous reset in the middle of WAIT_LOAD discards the load.
        drive(1, 5'd15, 0, 2'd1, 3'b010, 32'h0000_2000, 0, 32'h0, 0);
        tick();
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        #2;
        reset = 1'b0;
        m_reset();
        #1;
        chk("arst_regWrite", 32'(regWrite), 32'd1);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_retired", retired, 32'd0);
        chk("arst_stall", stallCycles, 32'd0);
        chk("arst_rd", 32'(rd), 32'd0);
        #2;
        reset = 1'b1;
        drive(0, 0, 1, 0, 0, 0, 0, 32'hCAFE_F00D, 1);
        tick();
        chk("arst_no_write", 32'(regWrite), 32'd1);
        chk("arst_no_retire", retired, 32'd0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            drive(($urandom % 4) != 0,
                  (($urandom % 8) == 0) ? 5'd0 : 5'($urandom),
                  ($urandom % 4) == 0,
                  2'($urandom),
                  3'($urandom),
                  $urandom, $urandom, $urandom,
                  ($urandom % 3) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register and writeback stage of the RISC-V merge-sort pipeline; feeds rd/regWrite/writeData directly into the register bank.
- Selects ALU result, extended cache load data, or PC+4; stalls upstream while a load waits on the data cache.
- Exposes retired-instruction and cache-stall counters for the merge-sort benchmark.

Parameters:
- XLEN, 32, datapath width
- CNT_W, 32, width of performance counters

Ports:
- clock  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- in_valid  in  1  EX/MEM slot holds a real instruction
- in_ready  out  1  stage can accept this cycle; 0 = stall upstream
- in_rd  in  5  destination register
- in_regWrite  in  1  active-low write enable (0 = write), same polarity as the register bank
- in_wbSel  in  2  0 ALU, 1 load, 2 PC+4, 3 reserved (treated as ALU)
- in_funct3  in  3  load size/sign
- in_aluResult  in  XLEN  ALU result / load address
- in_pcPlus4  in  XLEN  return address for jal/jalr
- cache_rdata  in  XLEN  aligned word from data cache
- cache_ready  in  1  cache_rdata valid for the current load
- rd  out  5  to register bank
- regWrite  out  1  to register bank, active-low
- writeData  out  XLEN  to register bank
- retired  out  CNT_W  instructions written back
- stallCycles  out  CNT_W  cycles spent in WAIT_LOAD

Behaviour:
- Reset (reset=0, asynchronous): rd=0, regWrite=1 (no write), writeData=0, retired=0, stallCycles=0, state=RUN.
- in_ready = (state==RUN). Accept = in_valid && in_ready.
- FSM RUN:
  - accept, wbSel!=1: next cycle rd=in_rd, writeData=ALU or PC+4, regWrite=in_regWrite. Latency 1.
  - accept, wbSel=1, cache_ready=1: next cycle writeData=extend(cache_rdata), regWrite=in_regWrite; stay RUN.
  - accept, wbSel=1, cache_ready=0: latch rd, regWrite, funct3, aluResult[1:0]; outputs become bubble (regWrite=1); go WAIT_LOAD.
  - no accept: bubble (regWrite=1, rd/writeData hold).
- FSM WAIT_LOAD: in_ready=0, regWrite=1, stallCycles+=1 per cycle. When cache_ready=1: next cycle writeData=extend(cache_rdata) using latched fields, regWrite=latched, return RUN. in_ready is 1 in that next cycle.
- Write suppression: regWrite output forced to 1 whenever its rd is 0.
- Output rd, regWrite and writeData are registered; regWrite=0 lasts exactly one cycle per instruction.
- retired increments by 1 in the cycle an output regWrite=0 is registered. Instructions with in_regWrite=1, e.g. stores and branches, are not counted. Both counters wrap modulo 2^CNT_W.
- Load extension, off = aluResult[1:0]:
  - lb 000: sign-extend byte off.
  - lbu 100: zero-extend byte off.
  - lh 001: sign-extend halfword off[1].
  - lhu 101: zero-extend halfword off[1].
  - lw 010: full word.
  - Any other funct3: full word.
  - Misaligned halfword (off[0]=1): off[0] ignored.
- Reset mid-WAIT_LOAD: the pending load is discarded and the stage returns to RUN with reset values.
- cache_ready while in RUN with no load accepted: ignored.

Decomposition:
- Shared package writeback_pkg:
  - wbSel codes: WB_ALU, WB_LOAD, WB_PC4.
  - funct3 load codes: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - State encoding: RUN, WAIT_LOAD.
- One sub-module: load_extender, combinational (word, funct3, off) -> XLEN result.

Test Plan:
- Reset, then addi path: reset=0 -> rd=0, regWrite=1, writeData=0. Accept rd=5, wbSel=0, aluResult=0x0000_002A, in_regWrite=0 -> next cycle rd=5, writeData=0x2A, regWrite=0, retired=1.
- Load hit lb: funct3=000, aluResult=0x103, cache_rdata=0x80FF_1234, cache_ready=1 -> writeData=0xFFFF_FF80. Repeat with lbu -> writeData=0x0000_0080.
- Load miss: lw rd=10, cache_ready low for 3 cycles, then 1 with rdata=0xDEAD_BEEF.
  - in_ready=0 for 3 cycles, and in_ready=0 also on the cycle cache_ready=1.
  - stallCycles=4.
  - The cycle after cache_ready=1: regWrite=0, writeData=0xDEAD_BEEF. Upstream instruction held and accepted in that cycle.
- jal: wbSel=2, pcPlus4=0x0000_0048, rd=1 -> writeData=0x48, regWrite=0. Store with in_regWrite=1 -> regWrite stays 1, retired unchanged.
- Write suppression: accept rd=0, in_regWrite=0, aluResult=0x7 -> regWrite=1 and retired unchanged.
- Reset during WAIT_LOAD: assert reset=0 asynchronously mid-wait -> immediately regWrite=1, in_ready=1, counters 0. Later cache_ready=1 produces no write.
